// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory block port between the I-cache and D-cache.
// Build option MEM_ARB_RR_EN selects round-robin arbitration; the default build uses fixed D-cache priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_valid,
  output logic [BLOCK_SIZE-1:0] i_rd,
  output logic                  i_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [BLOCK_SIZE-1:0] d_wr,
  input  logic                  d_rw,
  input  logic                  d_valid,
  output logic [BLOCK_SIZE-1:0] d_rd,
  output logic                  d_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wr,
  output logic                  mem_rw,
  output logic                  mem_valid,
  input  logic [BLOCK_SIZE-1:0] mem_rd,
  input  logic                  mem_ready,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;
  logic   win_i, win_d;

`ifdef MEM_ARB_RR_EN
  logic last_d;  // 1 when the D-cache was the most recent winner
`endif

  // Winner selection, only acted upon in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win_d = 1'b0;
    win_i = 1'b0;
`ifdef MEM_ARB_RR_EN
    win_d = d_valid & (~i_valid | ~last_d);
`else
    win_d = d_valid;
`endif
    win_i = i_valid & ~win_d;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_valid | d_valid) state_next = BUSY;
      BUSY:    if (mem_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Request registers: loaded at grant so memory sees a stable request even after withdrawal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= 2'b00;
      mem_addr <= '0;
      mem_wr   <= '0;
      mem_rw   <= 1'b0;
    end else if (state == IDLE && (win_i || win_d)) begin
      grant    <= {win_d, win_i};
      mem_addr <= win_d ? d_addr : i_addr;
      mem_rw   <= win_d & d_rw;
      mem_wr   <= (win_d && d_rw) ? d_wr : '0;
    end else if (state == BUSY && mem_ready) begin
      grant    <= 2'b00;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     last_d <= 1'b1;
    else if (state == IDLE && (win_i || win_d))     last_d <= win_d;
  end
`endif

  assign mem_valid = (state == BUSY);
  assign busy      = (state != IDLE);

  // Completion is forwarded only to a requester that is still asking.
  assign i_ready = mem_valid & grant[0] & mem_ready & i_valid;
  assign d_ready = mem_valid & grant[1] & mem_ready & d_valid;

  assign i_rd = mem_rd;
  assign d_rd = mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level model.
// Define MEM_ARB_RR_EN for both DUT and bench to check the round-robin build.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int BW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic          i_valid, d_valid, d_rw, mem_rw, mem_valid, mem_ready;
  logic [BW-1:0] i_rd, d_rd, d_wr, mem_wr, mem_rd;
  logic          i_ready, d_ready, busy;
  logic [1:0]    grant;

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_valid(i_valid), .i_rd(i_rd), .i_ready(i_ready),
    .d_addr(d_addr), .d_wr(d_wr), .d_rw(d_rw), .d_valid(d_valid),
    .d_rd(d_rd), .d_ready(d_ready),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rw(mem_rw), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_ready(mem_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    grant;
    logic [AW-1:0] addr;
    logic          rw;
    logic [BW-1:0] wr;
  } txn_t;

  txn_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Model: who owns the memory port (0 none, 1 I, 2 D) and whether the turnaround cycle is pending.
  int   owner = 0;
  bit   turnaround = 0;
  bit   last_d = 1;
  int   wait_cnt = 0;
  bit   i_done, d_done, just_granted;
  bit   exp_i_ready = 0, exp_d_ready = 0, exp_mem_valid = 0, exp_busy = 0;
  logic [1:0] exp_grant = 2'b00;
  int   n_grants = 0, n_ties = 0, n_withdraw = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void update_exp();
    exp_mem_valid = (owner != 0);
    exp_busy      = (owner != 0) || turnaround;
    exp_grant     = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    exp_i_ready   = (owner == 1) && mem_ready && i_valid;
    exp_d_ready   = (owner == 2) && mem_ready && d_valid;
  endfunction

  // Apply the arbitration rules to the inputs that were present at the clock edge just passed.
  function automatic void model_edge();
    int w;
    i_done = exp_i_ready;
    d_done = exp_d_ready;
    just_granted = 0;
    if (owner != 0) begin
      if (mem_ready) begin
        owner = 0;
        turnaround = 1;
      end
    end else if (turnaround) begin
      turnaround = 0;
    end else if (i_valid || d_valid) begin
      if (i_valid && d_valid) n_ties++;
`ifdef MEM_ARB_RR_EN
      if (i_valid && d_valid) w = last_d ? 1 : 2;
      else                    w = d_valid ? 2 : 1;
`else
      w = d_valid ? 2 : 1;
`endif
      owner = w;
      last_d = (w == 2);
      just_granted = 1;
      n_grants++;
      if (w == 1) exp_q.push_back('{2'b01, i_addr, 1'b0, '0});
      else        exp_q.push_back('{2'b10, d_addr, d_rw, d_rw ? d_wr : '0});
      wait_cnt = $urandom_range(0, 5);
    end
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] v;
    for (int k = 0; k < BW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void drive_next();
    if (i_done) i_valid = 1'b0;
    else if (owner == 1 && i_valid && $urandom_range(0, 15) == 0) begin
      i_valid = 1'b0;
      n_withdraw++;
    end else if (!i_valid && owner != 1 && $urandom_range(0, 3) == 0) begin
      i_valid = 1'b1;
      i_addr  = AW'($urandom);
    end

    if (d_done) d_valid = 1'b0;
    else if (owner == 2 && d_valid && $urandom_range(0, 15) == 0) begin
      d_valid = 1'b0;
      n_withdraw++;
    end else if (!d_valid && owner != 2 && $urandom_range(0, 3) == 0) begin
      d_valid = 1'b1;
      d_addr  = AW'($urandom);
      d_rw    = 1'($urandom_range(0, 1));
      d_wr    = rand_block();
    end

    mem_rd = rand_block();
    if (owner != 0) begin
      if (wait_cnt == 0) mem_ready = 1'b1;
      else begin
        mem_ready = 1'b0;
        wait_cnt--;
      end
    end else begin
      mem_ready = ($urandom_range(0, 7) == 0);  // spurious completions must be ignored
    end
  endfunction

  // Monitor: compares outputs on the falling edge and pops one expected request per new mem_valid.
  initial begin
    bit   mv_prev = 0;
    txn_t t;
    forever begin
      @(negedge clk);
      check("mem_valid", BW'(mem_valid), BW'(exp_mem_valid));
      check("busy", BW'(busy), BW'(exp_busy));
      check("grant", BW'(grant), BW'(exp_grant));
      check("i_ready", BW'(i_ready), BW'(exp_i_ready));
      check("d_ready", BW'(d_ready), BW'(exp_d_ready));
      if (exp_i_ready) check("i_rd", i_rd, mem_rd);
      if (exp_d_ready) check("d_rd", d_rd, mem_rd);
      if (mem_valid && !mv_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got mem_addr %0h expected no request at %0t", mem_addr, $time);
        end else begin
          t = exp_q.pop_front();
          check("req_grant", BW'(grant), BW'(t.grant));
          check("req_addr", BW'(mem_addr), BW'(t.addr));
          check("req_rw", BW'(mem_rw), BW'(t.rw));
          check("req_wr", mem_wr, t.wr);
        end
      end
      mv_prev = mem_valid;
    end
  end

  initial begin
    bit reset_done = 0;
    rst_n = 1'b0;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_rw = 1'b0; d_wr = '0;
    mem_ready = 1'b0; mem_rd = '0;
    #1;
    check("rst_mem_valid", BW'(mem_valid), '0);
    check("rst_grant", BW'(grant), '0);
    check("rst_busy", BW'(busy), '0);
    check("rst_mem_addr", BW'(mem_addr), '0);
    check("rst_mem_wr", mem_wr, '0);
    check("rst_mem_rw", BW'(mem_rw), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      model_edge();
      if (cyc >= 2000 && !reset_done && owner != 0 && !just_granted) begin
        // Abort a transaction in flight: outputs must drop immediately.
        reset_done = 1;
        rst_n = 1'b0;
        #1;
        check("abort_mem_valid", BW'(mem_valid), '0);
        check("abort_grant", BW'(grant), '0);
        check("abort_busy", BW'(busy), '0);
        check("abort_mem_addr", BW'(mem_addr), '0);
        check("abort_mem_wr", mem_wr, '0);
        owner = 0; turnaround = 0; last_d = 1;
        i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b1;
        update_exp();
        @(posedge clk);
        #1 rst_n = 1'b1;
        i_done = 0; d_done = 0;
        mem_ready = 1'b1;  // stray completion after reset
        update_exp();
        continue;
      end
      drive_next();
      update_exp();
    end

    i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("pending_requests", BW'(exp_q.size()), '0);
    if (n_grants < 100 || n_ties == 0 || n_withdraw == 0 || !reset_done) begin
      checks++;
      errors++;
      $display("FAIL coverage: got grants %0d ties %0d withdrawals %0d reset %0d expected activity in each",
               n_grants, n_ties, n_withdraw, reset_done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
